ad_sample_packer: RTL and testbench

//  - Stage directly downstream of the AD7606 read controller. Consumes its 16-bit

---
 rtl/ad_sample_packer.sv | 174 +++++++++++++++++
 tb/tb_ad_sample_packer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_sample_packer.sv
// ad_sample_packer: tags AD7606 sample strobes with a channel index, drops
// masked channels, packs kept samples in pairs into 32-bit words and buffers
// them in a first-word-fall-through FIFO with a valid/ready output.
module ad_sample_packer #(
  parameter logic [7:0]  CH_MASK  = 8'hFF,
  parameter int unsigned FIFO_AW  = 4,
  parameter logic [15:0] PAD_WORD = 16'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [15:0]        s_data,
  input  logic               s_valid,
  output logic [31:0]        m_data,
  output logic               m_sof,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  output logic               frame_err,
  input  logic               err_clr
);

  localparam int unsigned NCH   = 8;
  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;

  typedef enum logic {LOW = 1'b0, HALF = 1'b1} state_t;

  state_t        state, state_nxt, st_eff;
  logic [3:0]    ch_idx, ch_idx_nxt, idx_eff;
  logic          sof_pend, sof_pend_nxt;
  logic [15:0]   lo_reg, lo_reg_nxt;
  logic          lo_sof, lo_sof_nxt;
  logic          remain, keep, ferr_set;
  logic          push, push_sof;
  logic [31:0]   push_data;

  logic [FIFO_AW:0] wr_ptr, rd_ptr, level_nxt;
  logic [32:0]      mem [DEPTH];
  logic             full, pop, push_ok;

  // Any enabled channel at or above the current index still to come in this frame
  always_comb begin
    remain = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (CH_MASK[3'(i)] && (4'(i) >= ch_idx)) remain = 1'b1;
    end
  end

  // Packer next-state: frame_start first, then odd-count flush, then the sample
  always_comb begin
    state_nxt    = state;
    ch_idx_nxt   = ch_idx;
    sof_pend_nxt = sof_pend;
    lo_reg_nxt   = lo_reg;
    lo_sof_nxt   = lo_sof;
    st_eff       = state;
    idx_eff      = ch_idx;
    keep         = 1'b0;
    ferr_set     = 1'b0;
    push         = 1'b0;
    push_sof     = 1'b0;
    push_data    = '0;

    if (frame_start) begin
      st_eff       = LOW;
      idx_eff      = '0;
      ch_idx_nxt   = '0;
      sof_pend_nxt = 1'b1;
      if (state == HALF) begin
        ferr_set  = 1'b1;
        state_nxt = LOW;
      end
    end else if (state == HALF && !remain) begin
      push      = 1'b1;
      push_sof  = lo_sof;
      push_data = {PAD_WORD, lo_reg};
      state_nxt = LOW;
    end

    if (s_valid) begin
      if (idx_eff == 4'd8) begin
        ferr_set = 1'b1;
      end else begin
        ch_idx_nxt = idx_eff + 4'd1;
        keep       = CH_MASK[idx_eff[2:0]];
      end
    end

    // A flush only fires when no enabled channel remains, so it never meets keep
    if (keep) begin
      if (st_eff == LOW) begin
        lo_reg_nxt   = s_data;
        lo_sof_nxt   = sof_pend_nxt;
        sof_pend_nxt = 1'b0;
        state_nxt    = HALF;
      end else begin
        push      = 1'b1;
        push_sof  = lo_sof;
        push_data = {s_data, lo_reg};
        state_nxt = LOW;
      end
    end
  end

  // Packer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOW;
    else     state <= state_nxt;
  end

  // Packer datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_idx   <= '0;
      sof_pend <= 1'b0;
      lo_reg   <= '0;
      lo_sof   <= 1'b0;
    end else begin
      ch_idx   <= ch_idx_nxt;
      sof_pend <= sof_pend_nxt;
      lo_reg   <= lo_reg_nxt;
      lo_sof   <= lo_sof_nxt;
    end
  end

  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop     = m_valid & m_ready;
  assign push_ok = push & (~full | pop);

  // Word count after this cycle's push/pop
  always_comb begin
    level_nxt = fifo_level;
    if (push_ok && !pop)      level_nxt = fifo_level + LW'(1);
    else if (!push_ok && pop) level_nxt = fifo_level - LW'(1);
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= {push_sof, push_data};
  end

  // FIFO pointers, level and not-empty flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      m_valid    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + LW'(1);
      if (pop)     rd_ptr <= rd_ptr + LW'(1);
      fifo_level <= level_nxt;
      m_valid    <= (level_nxt != '0);
    end
  end

  // Head word falls through; forced to zero while the FIFO is empty
  assign {m_sof, m_data} = m_valid ? mem[rd_ptr[FIFO_AW-1:0]] : 33'h0;

  // Sticky error flags; a same-cycle error wins over err_clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= (overflow & ~err_clr) | (push & ~push_ok);
      frame_err <= (frame_err & ~err_clr) | ferr_set;
    end
  end

endmodule

// File: tb/tb_ad_sample_packer.sv
// Bench for ad_sample_packer: three instances (full mask, mask 8'h15 with a
// visible pad word, and a 4-deep FIFO) fed from one gated stimulus bus.
module tb_ad_sample_packer;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst, frame_start, s_valid, err_clr;
  logic [15:0] s_data;
  logic [2:0]  en;
  logic        m_ready_ff, m_ready_15, m_ready_ov;

  logic [31:0] m_data_ff, m_data_15, m_data_ov;
  logic        m_sof_ff, m_sof_15, m_sof_ov;
  logic        m_valid_ff, m_valid_15, m_valid_ov;
  logic [4:0]  lvl_ff, lvl_15;
  logic [2:0]  lvl_ov;
  logic        ovf_ff, ovf_15, ovf_ov;
  logic        ferr_ff, ferr_15, ferr_ov;

  int errors = 0;
  int checks = 0;

  logic [32:0] q_ff[$];
  logic [32:0] q_15[$];
  logic [32:0] q_ov[$];

  ad_sample_packer #(.CH_MASK(8'hFF), .FIFO_AW(4), .PAD_WORD(16'h0000)) dut_ff (
    .clk(clk), .rst(rst), .frame_start(frame_start & en[0]), .s_data(s_data),
    .s_valid(s_valid & en[0]), .m_data(m_data_ff), .m_sof(m_sof_ff),
    .m_valid(m_valid_ff), .m_ready(m_ready_ff), .fifo_level(lvl_ff),
    .overflow(ovf_ff), .frame_err(ferr_ff), .err_clr(err_clr));

  ad_sample_packer #(.CH_MASK(8'h15), .FIFO_AW(4), .PAD_WORD(16'hBEEF)) dut_15 (
    .clk(clk), .rst(rst), .frame_start(frame_start & en[1]), .s_data(s_data),
    .s_valid(s_valid & en[1]), .m_data(m_data_15), .m_sof(m_sof_15),
    .m_valid(m_valid_15), .m_ready(m_ready_15), .fifo_level(lvl_15),
    .overflow(ovf_15), .frame_err(ferr_15), .err_clr(err_clr));

  ad_sample_packer #(.CH_MASK(8'hFF), .FIFO_AW(2), .PAD_WORD(16'h0000)) dut_ov (
    .clk(clk), .rst(rst), .frame_start(frame_start & en[2]), .s_data(s_data),
    .s_valid(s_valid & en[2]), .m_data(m_data_ov), .m_sof(m_sof_ov),
    .m_valid(m_valid_ov), .m_ready(m_ready_ov), .fifo_level(lvl_ov),
    .overflow(ovf_ov), .frame_err(ferr_ov), .err_clr(err_clr));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int which, input logic [32:0] act);
    logic [32:0] exp;
    bit have;
    have = 1'b0;
    exp  = '0;
    case (which)
      0: if (q_ff.size() > 0) begin exp = q_ff.pop_front(); have = 1'b1; end
      1: if (q_15.size() > 0) begin exp = q_15.pop_front(); have = 1'b1; end
      default: if (q_ov.size() > 0) begin exp = q_ov.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_word dut%0d: got 0x%0h, expected none", which, act);
    end else begin
      check($sformatf("word_dut%0d", which), 64'(act), 64'(exp));
    end
  endtask

  // Output monitor: a handshake seen at the falling edge completes at the next rising edge
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid_ff && m_ready_ff) sb_pop(0, {m_sof_ff, m_data_ff});
      if (m_valid_15 && m_ready_15) sb_pop(1, {m_sof_15, m_data_15});
      if (m_valid_ov && m_ready_ov) sb_pop(2, {m_sof_ov, m_data_ov});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    tick(); err_clr = 1'b1;
    tick(); err_clr = 1'b0;
  endtask

  // One conversion: frame_start pulse, then n strobes separated by idle cycles
  task automatic drive_frame(input logic [15:0] base, input int n);
    tick(); frame_start = 1'b1; s_valid = 1'b0;
    tick(); frame_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = base + 16'(i);
      tick();
      s_valid = 1'b0;
      tick();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q_ff.size() == 0 && q_15.size() == 0 && q_ov.size() == 0) break;
      tick();
    end
    check("drain_ff", 64'(q_ff.size()), 64'd0);
    check("drain_15", 64'(q_15.size()), 64'd0);
    check("drain_ov", 64'(q_ov.size()), 64'd0);
  endtask

  // Frame-level reference for the CH1/CH3/CH5 instance: pair kept samples, pad an odd tail
  function automatic void model15(input logic [15:0] base, input int n);
    logic [7:0]  m;
    logic [15:0] kept[$];
    logic [15:0] hi;
    logic        s;
    m = 8'h15;
    for (int i = 0; i < n && i < 8; i++) begin
      if (m[i]) kept.push_back(base + 16'(i));
    end
    for (int k = 0; k < kept.size(); k += 2) begin
      hi = (k + 1 < kept.size()) ? kept[k+1] : 16'hBEEF;
      s  = (k == 0);
      q_15.push_back({s, hi, kept[k]});
    end
  endfunction

  typedef struct {
    logic [15:0]      base;
    int               n;
    logic [3:0][31:0] w;
    bit               ferr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic s;
    vecs[0] = '{16'h0001, 8, {32'h00080007, 32'h00060005, 32'h00040003, 32'h00020001}, 1'b0};
    vecs[1] = '{16'h1000, 8, {32'h10071006, 32'h10051004, 32'h10031002, 32'h10011000}, 1'b0};
    vecs[2] = '{16'hFFF8, 8, {32'hFFFFFFFE, 32'hFFFDFFFC, 32'hFFFBFFFA, 32'hFFF9FFF8}, 1'b0};
    vecs[3] = '{16'h8000, 9, {32'h80078006, 32'h80058004, 32'h80038002, 32'h80018000}, 1'b1};

    rst = 1'b1; frame_start = 1'b0; s_valid = 1'b0; s_data = '0; err_clr = 1'b0;
    en = 3'b000; m_ready_ff = 1'b0; m_ready_15 = 1'b0; m_ready_ov = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_m_valid", 64'(m_valid_ff), 64'd0);
    check("rst_m_data", 64'(m_data_ff), 64'd0);
    check("rst_m_sof", 64'(m_sof_ff), 64'd0);
    check("rst_level", 64'(lvl_ff), 64'd0);
    check("rst_overflow", 64'(ovf_ff), 64'd0);
    check("rst_frame_err", 64'(ferr_ff), 64'd0);
    tick(); rst = 1'b0;
    tick();

    // Table-driven frames on the full-mask and CH1/CH3/CH5 instances
    en = 3'b011; m_ready_ff = 1'b1; m_ready_15 = 1'b1;
    for (int v = 0; v < 4; v++) begin
      pulse_clr();
      for (int k = 0; k < 4; k++) begin
        s = (k == 0);
        q_ff.push_back({s, vecs[v].w[k]});
      end
      model15(vecs[v].base, vecs[v].n);
      drive_frame(vecs[v].base, vecs[v].n);
      drain();
      check($sformatf("ferr_ff_v%0d", v), 64'(ferr_ff), 64'(vecs[v].ferr));
      check($sformatf("ferr_15_v%0d", v), 64'(ferr_15), 64'(vecs[v].ferr));
    end

    // Reset mid-frame with two words queued and a half word pending
    en = 3'b001; m_ready_ff = 1'b0;
    drive_frame(16'h5000, 5);
    check("pre_rst_level", 64'(lvl_ff), 64'd2);
    rst = 1'b1;
    #3;
    check("mid_rst_m_valid", 64'(m_valid_ff), 64'd0);
    check("mid_rst_level", 64'(lvl_ff), 64'd0);
    check("mid_rst_frame_err", 64'(ferr_ff), 64'd0);
    check("mid_rst_overflow", 64'(ovf_ff), 64'd0);
    tick(); tick(); rst = 1'b0;
    m_ready_ff = 1'b1;
    q_ff.push_back({1'b1, 32'h60016000});
    q_ff.push_back({1'b0, 32'h60036002});
    q_ff.push_back({1'b0, 32'h60056004});
    q_ff.push_back({1'b0, 32'h60076006});
    drive_frame(16'h6000, 8);
    drain();
    check("post_rst_frame_err", 64'(ferr_ff), 64'd0);

    // frame_start arriving while a half word is pending
    pulse_clr();
    q_ff.push_back({1'b1, 32'h30013000});
    drive_frame(16'h3000, 3);
    q_ff.push_back({1'b1, 32'h40014000});
    q_ff.push_back({1'b0, 32'h40034002});
    q_ff.push_back({1'b0, 32'h40054004});
    q_ff.push_back({1'b0, 32'h40074006});
    drive_frame(16'h4000, 8);
    drain();
    check("midpair_frame_err", 64'(ferr_ff), 64'd1);
    pulse_clr();
    @(negedge clk);
    check("frame_err_cleared", 64'(ferr_ff), 64'd0);

    // Odd-count flush timing with back-to-back strobes, output held off
    en = 3'b010; m_ready_15 = 1'b0;
    tick(); frame_start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      frame_start = 1'b0;
      s_valid = 1'b1;
      s_data = 16'hA100 + 16'(i);
      if (i == 5) begin @(negedge clk); check("flush_not_yet", 64'(lvl_15), 64'd1); end
      if (i == 6) begin @(negedge clk); check("flush_pushed", 64'(lvl_15), 64'd2); end
    end
    tick(); s_valid = 1'b0;
    check("flush_head_held", 64'({m_sof_15, m_data_15}), 64'({1'b1, 32'hA102A100}));
    q_15.push_back({1'b1, 32'hA102A100});
    q_15.push_back({1'b0, 32'hBEEFA104});
    m_ready_15 = 1'b1;
    drain();

    // Overflow on the 4-deep instance with the output stalled
    en = 3'b100; m_ready_ov = 1'b0;
    pulse_clr();
    drive_frame(16'h0100, 8);
    check("ov_head_data", 64'(m_data_ov), 64'h01010100);
    check("ov_head_sof", 64'(m_sof_ov), 64'd1);
    check("ov_no_overflow_yet", 64'(ovf_ov), 64'd0);
    drive_frame(16'h0200, 8);
    drive_frame(16'h0300, 8);
    check("ov_level_full", 64'(lvl_ov), 64'd4);
    check("ov_overflow", 64'(ovf_ov), 64'd1);
    check("ov_head_stable", 64'({m_sof_ov, m_data_ov}), 64'({1'b1, 32'h01010100}));
    q_ov.push_back({1'b1, 32'h01010100});
    q_ov.push_back({1'b0, 32'h01030102});
    q_ov.push_back({1'b0, 32'h01050104});
    q_ov.push_back({1'b0, 32'h01070106});
    m_ready_ov = 1'b1;
    drain();
    @(negedge clk);
    check("ov_empty_valid", 64'(m_valid_ov), 64'd0);
    check("ov_empty_level", 64'(lvl_ov), 64'd0);
    check("ov_sticky", 64'(ovf_ov), 64'd1);
    m_ready_ov = 1'b0;
    pulse_clr();
    @(negedge clk);
    check("ov_cleared", 64'(ovf_ov), 64'd0);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
